pipe_seq: RTL and testbench

Parametrised pipeline sequencer for the next-generation 3-stage (Fetch/Decode/Execute) RNBIP core. It owns the PC and the D/E stage instruction registers with valid bits, and adds what the current core lacks: external stall, branch flush, load-use interlock and execute-to-decode operand forwarding. It sits between program memory, the decode/control logic, the register array and the ALU, replacing the free-running PC and the unconditional stage registers.

---
 rtl/pipe_pkg.sv | 18 +
 rtl/pipe_fwd_unit.sv | 18 +
 rtl/pipe_seq.sv | 122 ++++++++++++
 tb/tb_pipe_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and default widths for the pipe_seq sequencer and its helpers.
package pipe_pkg;

    localparam int unsigned PIPE_AW = 8;
    localparam int unsigned PIPE_IW = 16;
    localparam int unsigned PIPE_DW = 8;
    localparam int unsigned PIPE_RA = 3;
    localparam int unsigned PIPE_CW = 16;

    typedef enum logic [2:0] {
        ACT_RESET,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_BUBBLE,
        ACT_ADVANCE
    } pipe_act_e;

endpackage

// File: rtl/pipe_fwd_unit.sv
// Execute-to-decode forwarding: replaces register-array data with the E-stage result on an address hit.
module pipe_fwd_unit
    import pipe_pkg::*;
#(
    parameter int unsigned DW = PIPE_DW,
    parameter int unsigned RA = PIPE_RA
) (
    input  logic          fwd_ok,
    input  logic [RA-1:0] ex_wr_addr,
    input  logic [DW-1:0] ex_wr_data,
    input  logic [RA-1:0] rs,
    input  logic [DW-1:0] rf,
    output logic [DW-1:0] opnd
);

    assign opnd = (fwd_ok && (ex_wr_addr == rs)) ? ex_wr_data : rf;

endmodule

// File: rtl/pipe_seq.sv
// Fetch/Decode/Execute sequencer: PC, D/E stage registers, stall, flush, load-use interlock, forwarding.
module pipe_seq
    import pipe_pkg::*;
#(
    parameter int unsigned   AW      = PIPE_AW,
    parameter int unsigned   IW      = PIPE_IW,
    parameter int unsigned   DW      = PIPE_DW,
    parameter int unsigned   RA      = PIPE_RA,
    parameter int unsigned   CW      = PIPE_CW,
    parameter logic [AW-1:0] RST_VEC = '0
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] imem_addr,
    input  logic [IW-1:0] imem_data,
    input  logic          ext_stall,
    input  logic [RA-1:0] dec_rs_a,
    input  logic [RA-1:0] dec_rs_b,
    input  logic          dec_uses_a,
    input  logic          dec_uses_b,
    input  logic          ex_wr_en,
    input  logic [RA-1:0] ex_wr_addr,
    input  logic [DW-1:0] ex_wr_data,
    input  logic          ex_is_load,
    input  logic          br_taken,
    input  logic [AW-1:0] br_target,
    input  logic [DW-1:0] rf_a,
    input  logic [DW-1:0] rf_b,
    output logic [DW-1:0] opnd_a,
    output logic [DW-1:0] opnd_b,
    output logic [IW-1:0] ir_d,
    output logic [AW-1:0] npc_d,
    output logic          valid_d,
    output logic [IW-1:0] ir_e,
    output logic [AW-1:0] npc_e,
    output logic          valid_e,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);

    pipe_act_e act;
    logic      load_use;
    logic      fwd_ok;
    logic [AW-1:0] pc_inc;

    assign pc_inc = imem_addr + AW'(1);
    // Loads resolve in data memory, so their result cannot be forwarded.
    assign fwd_ok = valid_e && ex_wr_en && !ex_is_load;

    // Per-cycle stage action, highest priority first.
    always_comb begin
        act      = ACT_ADVANCE;
        load_use = valid_e && ex_wr_en && ex_is_load && valid_d &&
                   ((dec_uses_a && (dec_rs_a == ex_wr_addr)) ||
                    (dec_uses_b && (dec_rs_b == ex_wr_addr)));
        if (rst) begin
            act = ACT_RESET;
        end else if (ext_stall) begin
            act = ACT_HOLD;
        end else if (br_taken && valid_e) begin
            act = ACT_FLUSH;
        end else if (load_use) begin
            act = ACT_BUBBLE;
        end
    end

    always_ff @(posedge clk) begin
        case (act)
            ACT_RESET: begin
                imem_addr <= RST_VEC;
                ir_d      <= '0;
                npc_d     <= '0;
                valid_d   <= 1'b0;
                ir_e      <= '0;
                npc_e     <= '0;
                valid_e   <= 1'b0;
                stall_cnt <= '0;
                flush_cnt <= '0;
            end
            ACT_HOLD: begin
            end
            ACT_FLUSH: begin
                imem_addr <= br_target;
                valid_d   <= 1'b0;
                valid_e   <= 1'b0;
                if (flush_cnt != '1) flush_cnt <= flush_cnt + CW'(1);
            end
            ACT_BUBBLE: begin
                valid_e <= 1'b0;
                if (stall_cnt != '1) stall_cnt <= stall_cnt + CW'(1);
            end
            default: begin
                imem_addr <= pc_inc;
                ir_d      <= imem_data;
                npc_d     <= pc_inc;
                valid_d   <= 1'b1;
                ir_e      <= ir_d;
                npc_e     <= npc_d;
                valid_e   <= valid_d;
            end
        endcase
    end

    pipe_fwd_unit #(.DW(DW), .RA(RA)) u_fwd_a (
        .fwd_ok     (fwd_ok),
        .ex_wr_addr (ex_wr_addr),
        .ex_wr_data (ex_wr_data),
        .rs         (dec_rs_a),
        .rf         (rf_a),
        .opnd       (opnd_a)
    );

    pipe_fwd_unit #(.DW(DW), .RA(RA)) u_fwd_b (
        .fwd_ok     (fwd_ok),
        .ex_wr_addr (ex_wr_addr),
        .ex_wr_data (ex_wr_data),
        .rs         (dec_rs_b),
        .rf         (rf_b),
        .opnd       (opnd_b)
    );

endmodule

// File: tb/tb_pipe_seq.sv
// Randomized scoreboard bench for pipe_seq against a cycle-level pipeline occupancy model.
module tb_pipe_seq;

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;
    localparam int unsigned DW = 8;
    localparam int unsigned RA = 3;
    localparam int unsigned CW = 2;
    localparam int unsigned NCYC = 3000;
    localparam int SAT = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [IW-1:0] imem_data;
    logic          ext_stall;
    logic [RA-1:0] dec_rs_a, dec_rs_b;
    logic          dec_uses_a, dec_uses_b;
    logic          ex_wr_en;
    logic [RA-1:0] ex_wr_addr;
    logic [DW-1:0] ex_wr_data;
    logic          ex_is_load;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [DW-1:0] rf_a, rf_b;
    logic [DW-1:0] opnd_a, opnd_b;
    logic [IW-1:0] ir_d, ir_e;
    logic [AW-1:0] npc_d, npc_e;
    logic          valid_d, valid_e;
    logic [CW-1:0] stall_cnt, flush_cnt;

    logic [IW-1:0] mem [0:(1<<AW)-1];
    assign imem_data = mem[imem_addr];

    pipe_seq #(.AW(AW), .IW(IW), .DW(DW), .RA(RA), .CW(CW), .RST_VEC(8'h00)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .ext_stall(ext_stall), .dec_rs_a(dec_rs_a), .dec_rs_b(dec_rs_b),
        .dec_uses_a(dec_uses_a), .dec_uses_b(dec_uses_b), .ex_wr_en(ex_wr_en),
        .ex_wr_addr(ex_wr_addr), .ex_wr_data(ex_wr_data), .ex_is_load(ex_is_load),
        .br_taken(br_taken), .br_target(br_target), .rf_a(rf_a), .rf_b(rf_b),
        .opnd_a(opnd_a), .opnd_b(opnd_b), .ir_d(ir_d), .npc_d(npc_d), .valid_d(valid_d),
        .ir_e(ir_e), .npc_e(npc_e), .valid_e(valid_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          vd;
        logic          dk;
        logic [IW-1:0] ird;
        logic [AW-1:0] npcd;
        logic          ve;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
    } st_t;
    typedef struct packed {
        logic [IW-1:0] ir;
        logic [AW-1:0] npc;
    } e_t;
    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } op_t;

    st_t st_q [$];
    e_t  e_q  [$];
    op_t op_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    logic [AW-1:0] m_pc, m_npcd, m_npce;
    logic [IW-1:0] m_ird, m_ire;
    logic          m_dv, m_ev, m_dk;
    int            m_sc, m_fc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic hit(input logic uses, input logic [RA-1:0] rs);
        return uses && (rs == ex_wr_addr);
    endfunction

    // Advance the model across the edge just taken, using the inputs held at that edge.
    task automatic model_step();
        if (rst) begin
            m_pc = 8'h00; m_dv = 1'b0; m_ev = 1'b0; m_dk = 1'b1;
            m_ird = '0; m_npcd = '0; m_ire = '0; m_npce = '0;
            m_sc = 0; m_fc = 0;
        end else if (ext_stall) begin
            // whole pipe frozen
        end else if (br_taken && m_ev) begin
            m_pc = br_target; m_dv = 1'b0; m_ev = 1'b0; m_dk = 1'b0;
            m_fc = m_fc + 1;
        end else if (m_ev && ex_wr_en && ex_is_load && m_dv &&
                     (hit(dec_uses_a, dec_rs_a) || hit(dec_uses_b, dec_rs_b))) begin
            m_ev = 1'b0;
            m_sc = m_sc + 1;
        end else begin
            m_ire = m_ird; m_npce = m_npcd; m_ev = m_dv;
            m_ird = mem[m_pc]; m_npcd = m_pc + 8'd1; m_dv = 1'b1; m_dk = 1'b1;
            m_pc = m_pc + 8'd1;
        end
    endtask

    task automatic drive_random();
        rst        = ($urandom_range(0, 199) == 0);
        ext_stall  = ($urandom_range(0, 7) == 0);
        br_taken   = ($urandom_range(0, 5) == 0);
        case ($urandom_range(0, 3))
            0:       br_target = 8'h40;
            1:       br_target = 8'hFE;
            default: br_target = 8'($urandom);
        endcase
        dec_rs_a   = 3'($urandom);
        dec_rs_b   = 3'($urandom);
        dec_uses_a = 1'($urandom_range(0, 1));
        dec_uses_b = 1'($urandom_range(0, 1));
        ex_wr_en   = ($urandom_range(0, 3) != 0);
        ex_is_load = 1'($urandom_range(0, 1));
        ex_wr_addr = 3'($urandom);
        ex_wr_data = 8'($urandom);
        rf_a       = 8'($urandom);
        rf_b       = 8'($urandom);
    endtask

    initial begin
        st_t s;
        op_t o;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
        mem[0] = 16'h1234;
        mem[8'h40] = 16'hB040;
        rst = 1'b1; ext_stall = 1'b0; br_taken = 1'b0; br_target = '0;
        dec_rs_a = '0; dec_rs_b = '0; dec_uses_a = 1'b0; dec_uses_b = 1'b0;
        ex_wr_en = 1'b0; ex_wr_addr = '0; ex_wr_data = '0; ex_is_load = 1'b0;
        rf_a = '0; rf_b = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            model_step();
            s.pc = m_pc; s.vd = m_dv; s.dk = m_dk; s.ird = m_ird; s.npcd = m_npcd;
            s.ve = m_ev;
            s.sc = CW'((m_sc > SAT) ? SAT : m_sc);
            s.fc = CW'((m_fc > SAT) ? SAT : m_fc);
            st_q.push_back(s);
            if (m_ev) e_q.push_back({m_ire, m_npce});
            if (c < 2) begin
                rst = (c == 0) ? 1'b1 : 1'b0;
                ext_stall = 1'b0; br_taken = 1'b0;
            end else begin
                drive_random();
            end
            o.a = (m_ev && ex_wr_en && !ex_is_load && ex_wr_addr == dec_rs_a) ? ex_wr_data : rf_a;
            o.b = (m_ev && ex_wr_en && !ex_is_load && ex_wr_addr == dec_rs_b) ? ex_wr_data : rf_b;
            op_q.push_back(o);
        end
        @(negedge clk);
        #1;
        chk("st_q_left", 32'(st_q.size()), 32'd0);
        chk("e_q_left", 32'(e_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Monitor: state every cycle, E-stage payload whenever the DUT presents valid_e.
    always @(negedge clk) begin
        st_t s;
        e_t  e;
        op_t o;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("imem_addr", 32'(imem_addr), 32'(s.pc));
            chk("valid_d", 32'(valid_d), 32'(s.vd));
            chk("valid_e", 32'(valid_e), 32'(s.ve));
            chk("stall_cnt", 32'(stall_cnt), 32'(s.sc));
            chk("flush_cnt", 32'(flush_cnt), 32'(s.fc));
            if (s.dk) begin
                chk("ir_d", 32'(ir_d), 32'(s.ird));
                chk("npc_d", 32'(npc_d), 32'(s.npcd));
            end
        end
        if (op_q.size() > 0) begin
            o = op_q.pop_front();
            chk("opnd_a", 32'(opnd_a), 32'(o.a));
            chk("opnd_b", 32'(opnd_b), 32'(o.b));
        end
        if (valid_e === 1'b1) begin
            if (e_q.size() > 0) begin
                e = e_q.pop_front();
                chk("ir_e", 32'(ir_e), 32'(e.ir));
                chk("npc_e", 32'(npc_e), 32'(e.npc));
            end else begin
                chk("e_q_underflow", 32'd1, 32'(e_q.size()));
            end
        end
    end

endmodule
